// File: rtl/p2s_shift_ack.sv
// p2s_shift_ack: parallel-to-serial transmitter for an IIC master datapath.
// A WIDTH-bit word is accepted on valid & ready and shifted out one bit per SCL low phase.
// An optional ACK slot can follow the last bit. SCL is oversampled in the CLK domain.
//
// Ports:
//   CLK      in   system clock, all state on posedge
//   RST      in   asynchronous active-high reset
//   SCL      in   bus clock, asynchronous, synchronised internally
//   DATA_IN  in   word to transmit, captured on load
//   valid    in   word available; load on valid & ready
//   ready    out  block idle, can accept a word
//   SDA_OUT  out  serial bit value, meaningful when SDA_OE=1
//   SDA_OE   out  1: drive SDA_OUT onto the pad; 0: release the line
//   SDA_IN   in   pad SDA value, sampled in the ACK slot
//   p2s_end  out  one-CLK pulse when the word (and ACK slot, if enabled) completes
//   ack_ok   out  last ACK slot saw SDA_IN=0; held until the next ACK slot
module p2s_shift_ack #(
    parameter int unsigned WIDTH       = 8,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter bit          ACK_EN      = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SCL,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             valid,
    output logic             ready,
    output logic             SDA_OUT,
    output logic             SDA_OE,
    input  logic             SDA_IN,
    output logic             p2s_end,
    output logic             ack_ok
);

    localparam int unsigned    CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLast,
        StAck
    } state_e;

    state_e                 r_state;
    state_e                 w_state_d;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [WIDTH-1:0]       r_shreg;
    logic [WIDTH-1:0]       w_shreg_d;
    logic [CntW-1:0]        r_cnt;
    logic [CntW-1:0]        w_cnt_d;
    logic                   r_sda_out;
    logic                   w_sda_out_d;
    logic                   r_sda_oe;
    logic                   w_sda_oe_d;
    logic                   r_p2s_end;
    logic                   w_p2s_end_d;
    logic                   r_ack_ok;
    logic                   w_ack_ok_d;

    logic                   w_scl_s;
    logic                   w_scl_fall;
    logic                   w_scl_rise;
    logic                   w_next_bit;
    logic [WIDTH-1:0]       w_shifted;

    // SCL synchroniser plus history flop; reset to 1s so an idle-high bus gives no edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], SCL};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl_s    = r_sync[SYNC_STAGES-1];
    assign w_scl_fall = r_hist & ~w_scl_s;
    assign w_scl_rise = ~r_hist & w_scl_s;

    assign w_next_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_shifted  = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= StIdle;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_sda_out <= 1'b1;
            r_sda_oe  <= 1'b0;
            r_p2s_end <= 1'b0;
            r_ack_ok  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_shreg   <= w_shreg_d;
            r_cnt     <= w_cnt_d;
            r_sda_out <= w_sda_out_d;
            r_sda_oe  <= w_sda_oe_d;
            r_p2s_end <= w_p2s_end_d;
            r_ack_ok  <= w_ack_ok_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_shreg_d   = r_shreg;
        w_cnt_d     = r_cnt;
        w_sda_out_d = r_sda_out;
        w_sda_oe_d  = r_sda_oe;
        w_p2s_end_d = 1'b0;
        w_ack_ok_d  = r_ack_ok;

        unique case (r_state)
            StIdle: begin
                // After a no-ACK word the last bit is held until the next fall for hold time.
                if (w_scl_fall) begin
                    w_sda_oe_d  = 1'b0;
                    w_sda_out_d = 1'b1;
                end
                if (valid) begin
                    w_shreg_d = DATA_IN;
                    w_cnt_d   = CntInit;
                    w_state_d = StShift;
                end
            end
            StShift: begin
                if (w_scl_fall) begin
                    if (r_cnt != '0) begin
                        w_sda_oe_d  = 1'b1;
                        w_sda_out_d = w_next_bit;
                        w_shreg_d   = w_shifted;
                        w_cnt_d     = r_cnt - CntOne;
                        // Without an ACK slot the word ends on this last bit's high phase.
                        if (r_cnt == CntOne && !ACK_EN) begin
                            w_state_d = StLast;
                        end
                    end else begin
                        w_sda_oe_d = 1'b0;
                        w_state_d  = StAck;
                    end
                end
            end
            StLast: begin
                if (w_scl_rise) begin
                    w_p2s_end_d = 1'b1;
                    w_state_d   = StIdle;
                end
            end
            StAck: begin
                w_sda_oe_d = 1'b0;
                if (w_scl_rise) begin
                    w_ack_ok_d  = ~SDA_IN;
                    w_p2s_end_d = 1'b1;
                    w_state_d   = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign ready   = (r_state == StIdle);
    assign SDA_OUT = r_sda_out;
    assign SDA_OE  = r_sda_oe;
    assign p2s_end = r_p2s_end;
    assign ack_ok  = r_ack_ok;

endmodule
